// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, the zero-register constant and EX control-bundle bit positions
// for the ID/EX operand stage.
package id_ex_operand_stage_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 16;

    // Architectural zero register; reads as zero and is never a real producer.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bit positions inside the opaque EX/MEM/WB control bundle.
    // The stage passes the bundle through untouched; these document the layout
    // for downstream stages.
    localparam int CTRL_ALU_OP_LSB  = 0;
    localparam int CTRL_ALU_OP_MSB  = 3;
    localparam int CTRL_ALU_SRC_IMM = 4;
    localparam int CTRL_MEM_WRITE   = 5;
    localparam int CTRL_BRANCH      = 6;
    localparam int CTRL_MEM_TO_REG  = 7;

endpackage

// File: rtl/id_ex_operand_stage_operand_bypass_mux.sv
// Single-source operand select: zero register, then MEM bypass, then WB
// bypass, then register-file data.
module operand_bypass_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = id_ex_operand_stage_pkg::DATA_W,
    parameter int ADDR_W = id_ex_operand_stage_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              mem_reg_write_i,
    input  logic [ADDR_W-1:0] mem_dst_addr_i,
    input  logic              mem_fwd_ok_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              wb_reg_write_i,
    input  logic [ADDR_W-1:0] wb_dst_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] val_o
);

    // Prioritised operand select; WB bypass covers the same-edge write/read
    // where the register file still returns the old value.
    always_comb begin
        val_o = rf_data_i;
        if (addr_i == ADDR_W'(REG_ZERO)) begin
            val_o = {DATA_W{1'b0}};
        end else if (mem_reg_write_i && (mem_dst_addr_i == addr_i) && mem_fwd_ok_i) begin
            val_o = mem_data_i;
        end else if (wb_reg_write_i && (wb_dst_addr_i == addr_i)) begin
            val_o = wb_data_i;
        end else begin
            val_o = rf_data_i;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB bypassing, zero-register handling,
// load-use / no-EX-bypass hazard stalls, branch flush and a saturating stall
// counter.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = id_ex_operand_stage_pkg::DATA_W,
    parameter int ADDR_W = id_ex_operand_stage_pkg::ADDR_W,
    parameter int CTRL_W = id_ex_operand_stage_pkg::CTRL_W,
    parameter int CNT_W  = id_ex_operand_stage_pkg::CNT_W
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              ID_valid,
    input  logic [ADDR_W-1:0] ID_rs_addr,
    input  logic [ADDR_W-1:0] ID_rt_addr,
    input  logic              ID_uses_rt,
    input  logic [DATA_W-1:0] ID_rs_data,
    input  logic [DATA_W-1:0] ID_rt_data,
    input  logic [ADDR_W-1:0] ID_dst_addr,
    input  logic [DATA_W-1:0] ID_imm,
    input  logic              ID_reg_write,
    input  logic              ID_mem_read,
    input  logic [CTRL_W-1:0] ID_ctrl,
    input  logic              MEM_reg_write,
    input  logic [ADDR_W-1:0] MEM_dst_addr,
    input  logic              MEM_fwd_ok,
    input  logic [DATA_W-1:0] MEM_data,
    input  logic              WB_reg_write,
    input  logic [ADDR_W-1:0] WB_dst_addr,
    input  logic [DATA_W-1:0] WB_data,
    input  logic              PIPE_flush,
    output logic              ID_stall,
    output logic              EX_valid,
    output logic [DATA_W-1:0] EX_rs_val,
    output logic [DATA_W-1:0] EX_rt_val,
    output logic [DATA_W-1:0] EX_imm,
    output logic [ADDR_W-1:0] EX_dst_addr,
    output logic              EX_reg_write,
    output logic              EX_mem_read,
    output logic [CTRL_W-1:0] EX_ctrl,
    output logic [CNT_W-1:0]  STALL_cnt
);

    // Pipeline register state
    logic              valid_q,     valid_d;
    logic [DATA_W-1:0] rs_val_q,    rs_val_d;
    logic [DATA_W-1:0] rt_val_q,    rt_val_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic [ADDR_W-1:0] dst_q,       dst_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    // Combinational helpers
    logic [DATA_W-1:0] rs_sel_s;
    logic [DATA_W-1:0] rt_sel_s;
    logic              rs_read_s;
    logic              rt_read_s;
    logic              ex_hazard_s;
    logic              mem_hazard_s;
    logic              stall_s;

    operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_mux (
        .addr_i          (ID_rs_addr),
        .rf_data_i       (ID_rs_data),
        .mem_reg_write_i (MEM_reg_write),
        .mem_dst_addr_i  (MEM_dst_addr),
        .mem_fwd_ok_i    (MEM_fwd_ok),
        .mem_data_i      (MEM_data),
        .wb_reg_write_i  (WB_reg_write),
        .wb_dst_addr_i   (WB_dst_addr),
        .wb_data_i       (WB_data),
        .val_o           (rs_sel_s)
    );

    operand_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_mux (
        .addr_i          (ID_rt_addr),
        .rf_data_i       (ID_rt_data),
        .mem_reg_write_i (MEM_reg_write),
        .mem_dst_addr_i  (MEM_dst_addr),
        .mem_fwd_ok_i    (MEM_fwd_ok),
        .mem_data_i      (MEM_data),
        .wb_reg_write_i  (WB_reg_write),
        .wb_dst_addr_i   (WB_dst_addr),
        .wb_data_i       (WB_data),
        .val_o           (rt_sel_s)
    );

    // Hazard detection: EX has no bypass path, MEM can only bypass final data.
    always_comb begin
        rs_read_s    = ID_valid && (ID_rs_addr != ADDR_W'(REG_ZERO));
        rt_read_s    = ID_valid && ID_uses_rt && (ID_rt_addr != ADDR_W'(REG_ZERO));
        ex_hazard_s  = valid_q && reg_write_q &&
                       ((rs_read_s && (dst_q == ID_rs_addr)) ||
                        (rt_read_s && (dst_q == ID_rt_addr)));
        mem_hazard_s = MEM_reg_write && !MEM_fwd_ok &&
                       ((rs_read_s && (MEM_dst_addr == ID_rs_addr)) ||
                        (rt_read_s && (MEM_dst_addr == ID_rt_addr)));
        if (PIPE_flush) begin
            stall_s = 1'b0;
        end else begin
            stall_s = ex_hazard_s || mem_hazard_s;
        end
    end

    // Next-state for the pipeline register: flush > stall bubble > capture.
    always_comb begin
        valid_d     = valid_q;
        rs_val_d    = rs_val_q;
        rt_val_d    = rt_val_q;
        imm_d       = imm_q;
        dst_d       = dst_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        ctrl_d      = ctrl_q;
        if (PIPE_flush || stall_s) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else begin
            valid_d     = ID_valid;
            rs_val_d    = rs_sel_s;
            rt_val_d    = rt_sel_s;
            imm_d       = ID_imm;
            dst_d       = ID_dst_addr;
            reg_write_d = ID_reg_write && ID_valid;
            mem_read_d  = ID_mem_read && ID_valid;
            ctrl_d      = ID_ctrl;
        end
    end

    // Saturating stall counter next-state.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // ID/EX register and counter with asynchronous clear.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            valid_q     <= 1'b0;
            rs_val_q    <= {DATA_W{1'b0}};
            rt_val_q    <= {DATA_W{1'b0}};
            imm_q       <= {DATA_W{1'b0}};
            dst_q       <= {ADDR_W{1'b0}};
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            ctrl_q      <= {CTRL_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            valid_q     <= valid_d;
            rs_val_q    <= rs_val_d;
            rt_val_q    <= rt_val_d;
            imm_q       <= imm_d;
            dst_q       <= dst_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ID_stall     = stall_s;
    assign EX_valid     = valid_q;
    assign EX_rs_val    = rs_val_q;
    assign EX_rt_val    = rt_val_q;
    assign EX_imm       = imm_q;
    assign EX_dst_addr  = dst_q;
    assign EX_reg_write = reg_write_q;
    assign EX_mem_read  = mem_read_q;
    assign EX_ctrl      = ctrl_q;
    assign STALL_cnt    = cnt_q;

endmodule
